// File: rtl/atm_controller_p.sv
// ATM session controller: per-account balance/PIN/lock database with PIN
// authentication, lockout, bounded per-session withdrawals and idle timeout.
module atm_controller_p #(
    parameter int                NUM_ACCOUNTS   = 10,
    parameter int                ACC_W          = 4,
    parameter int                PIN_W          = 16,
    parameter int                AMT_W          = 32,
    parameter logic [AMT_W-1:0]  INIT_BALANCE   = AMT_W'(500),
    parameter logic [PIN_W-1:0]  DEFAULT_PIN    = PIN_W'(16'h1234),
    parameter int                MAX_TRIES      = 3,
    parameter int                TIMEOUT_CYCLES = 16,
    parameter logic [AMT_W-1:0]  WITHDRAW_LIMIT = AMT_W'(2000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_valid,
    input  logic [ACC_W-1:0] acc_num,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin,
    input  logic             op_valid,
    input  logic [2:0]       operation,
    input  logic [AMT_W-1:0] amount,
    input  logic [PIN_W-1:0] new_pin,
    output logic [2:0]       state,
    output logic [AMT_W-1:0] balance,
    output logic             done,
    output logic [2:0]       status,
    output logic             locked
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_AUTH       = 3'd1,
        S_MENU       = 3'd2,
        S_BALANCE    = 3'd3,
        S_WITHDRAW   = 3'd4,
        S_DEPOSIT    = 3'd5,
        S_CHANGE_PIN = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_BAD_PIN      = 3'd1,
        ST_LOCKED       = 3'd2,
        ST_INSUFFICIENT = 3'd3,
        ST_LIMIT        = 3'd4,
        ST_BAD_ACCOUNT  = 3'd5,
        ST_TIMEOUT      = 3'd6,
        ST_OVERFLOW     = 3'd7
    } status_e;

    state_e            state_q, state_d;
    status_e           status_q, status_d;
    logic [ACC_W-1:0]  idx_q, idx_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [AMT_W-1:0]  wd_q, wd_d;
    logic [AMT_W-1:0]  amt_q, amt_d;
    logic [PIN_W-1:0]  npin_q, npin_d;
    logic [PIN_W-1:0]  cpin_q, cpin_d;
    logic [AMT_W-1:0]  balance_q, balance_d;
    logic              done_q, done_d;
    logic              locked_q, locked_d;

    // Database write port, always addressed by the latched session index
    logic              bal_we;
    logic [AMT_W-1:0]  bal_wdata;
    logic              pin_we;
    logic              lock_set;

    logic [AMT_W-1:0]        bal_rd  [NUM_ACCOUNTS];
    logic [PIN_W-1:0]        pin_rd  [NUM_ACCOUNTS];
    logic [NUM_ACCOUNTS-1:0] lock_rd;

    for (genvar gi = 0; gi < NUM_ACCOUNTS; gi++) begin : g_acct
        logic [AMT_W-1:0] bal_q;
        logic [PIN_W-1:0] acct_pin_q;
        logic             lock_q;
        logic             sel;

        assign sel = (idx_q == ACC_W'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                bal_q      <= INIT_BALANCE;
                acct_pin_q <= DEFAULT_PIN;
                lock_q     <= 1'b0;
            end else if (sel) begin
                if (bal_we)   bal_q      <= bal_wdata;
                if (pin_we)   acct_pin_q <= npin_q;
                if (lock_set) lock_q     <= 1'b1;
            end
        end

        assign bal_rd[gi]  = bal_q;
        assign pin_rd[gi]  = acct_pin_q;
        assign lock_rd[gi] = lock_q;
    end

    logic             acc_ok;
    logic [AMT_W-1:0] cur_bal;
    logic [PIN_W-1:0] cur_pin;
    logic [AMT_W:0]   wd_sum;
    logic [AMT_W:0]   dep_sum;
    logic [AMT_W-1:0] new_bal;
    logic             timeout_hit;

    assign acc_ok      = (32'(acc_num) < NUM_ACCOUNTS);
    assign cur_bal     = bal_rd[idx_q];
    assign cur_pin     = pin_rd[idx_q];
    assign wd_sum      = {1'b0, wd_q} + {1'b0, amt_q};
    assign dep_sum     = {1'b0, cur_bal} + {1'b0, amt_q};
    assign new_bal     = cur_bal - amt_q;
    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        idx_d     = idx_q;
        tries_d   = tries_q;
        timer_d   = timer_q;
        wd_d      = wd_q;
        amt_d     = amt_q;
        npin_d    = npin_q;
        cpin_d    = cpin_q;
        balance_d = balance_q;
        done_d    = 1'b0;
        locked_d  = locked_q;
        bal_we    = 1'b0;
        bal_wdata = cur_bal;
        pin_we    = 1'b0;
        lock_set  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                balance_d = '0;
                timer_d   = '0;
                if (card_valid) begin
                    if (!acc_ok) begin
                        done_d   = 1'b1;
                        status_d = ST_BAD_ACCOUNT;
                    end else if (lock_rd[acc_num]) begin
                        done_d   = 1'b1;
                        status_d = ST_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        idx_d     = acc_num;
                        tries_d   = '0;
                        locked_d  = 1'b0;
                        balance_d = bal_rd[acc_num];
                        state_d   = S_AUTH;
                    end
                end
            end

            S_AUTH: begin
                if (pin_valid) begin
                    timer_d = '0;
                    done_d  = 1'b1;
                    if (pin == cur_pin) begin
                        state_d  = S_MENU;
                        wd_d     = '0;
                        tries_d  = '0;
                        status_d = ST_OK;
                    end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                        tries_d   = tries_q + 1'b1;
                        lock_set  = 1'b1;
                        locked_d  = 1'b1;
                        status_d  = ST_LOCKED;
                        state_d   = S_IDLE;
                        balance_d = '0;
                    end else begin
                        tries_d  = tries_q + 1'b1;
                        status_d = ST_BAD_PIN;
                    end
                end else if (timeout_hit) begin
                    timer_d   = '0;
                    done_d    = 1'b1;
                    status_d  = ST_TIMEOUT;
                    state_d   = S_IDLE;
                    balance_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_MENU: begin
                // Unknown operation codes are not accepted and let the timer run
                if (op_valid && operation >= 3'd1 && operation <= 3'd5) begin
                    timer_d = '0;
                    amt_d   = amount;
                    npin_d  = new_pin;
                    cpin_d  = pin;
                    unique case (operation)
                        3'd1:    state_d = S_BALANCE;
                        3'd2:    state_d = S_WITHDRAW;
                        3'd3:    state_d = S_DEPOSIT;
                        3'd4:    state_d = S_CHANGE_PIN;
                        default: begin
                            state_d   = S_IDLE;
                            done_d    = 1'b1;
                            status_d  = ST_OK;
                            balance_d = '0;
                        end
                    endcase
                end else if (timeout_hit) begin
                    timer_d   = '0;
                    done_d    = 1'b1;
                    status_d  = ST_TIMEOUT;
                    state_d   = S_IDLE;
                    balance_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_BALANCE: begin
                timer_d  = '0;
                done_d   = 1'b1;
                status_d = ST_OK;
                state_d  = S_MENU;
            end

            S_WITHDRAW: begin
                timer_d = '0;
                done_d  = 1'b1;
                state_d = S_MENU;
                // Insufficient funds outranks the session limit
                if (amt_q > cur_bal) begin
                    status_d = ST_INSUFFICIENT;
                end else if (wd_sum > {1'b0, WITHDRAW_LIMIT}) begin
                    status_d = ST_LIMIT;
                end else begin
                    status_d  = ST_OK;
                    bal_we    = 1'b1;
                    bal_wdata = new_bal;
                    balance_d = new_bal;
                    wd_d      = wd_sum[AMT_W-1:0];
                end
            end

            S_DEPOSIT: begin
                timer_d = '0;
                done_d  = 1'b1;
                state_d = S_MENU;
                if (dep_sum[AMT_W]) begin
                    status_d = ST_OVERFLOW;
                end else begin
                    status_d  = ST_OK;
                    bal_we    = 1'b1;
                    bal_wdata = dep_sum[AMT_W-1:0];
                    balance_d = dep_sum[AMT_W-1:0];
                end
            end

            S_CHANGE_PIN: begin
                timer_d = '0;
                done_d  = 1'b1;
                state_d = S_MENU;
                if (cpin_q != cur_pin) begin
                    status_d = ST_BAD_PIN;
                end else begin
                    status_d = ST_OK;
                    pin_we   = 1'b1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                balance_d = '0;
                timer_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            status_q  <= ST_OK;
            idx_q     <= '0;
            tries_q   <= '0;
            timer_q   <= '0;
            wd_q      <= '0;
            amt_q     <= '0;
            npin_q    <= '0;
            cpin_q    <= '0;
            balance_q <= '0;
            done_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            idx_q     <= idx_d;
            tries_q   <= tries_d;
            timer_q   <= timer_d;
            wd_q      <= wd_d;
            amt_q     <= amt_d;
            npin_q    <= npin_d;
            cpin_q    <= cpin_d;
            balance_q <= balance_d;
            done_q    <= done_d;
            locked_q  <= locked_d;
        end
    end

    assign state   = state_q;
    assign balance = balance_q;
    assign done    = done_q;
    assign status  = status_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_atm_controller_p.sv
// Directed bench for atm_controller_p: login, transactions, lockout,
// overflow, PIN change, timeout and reset-abandon, checked with assertions.
module tb_atm_controller_p;

    logic        clk;
    logic        rst;
    logic        card_valid;
    logic [3:0]  acc_num;
    logic        pin_valid;
    logic [15:0] pin;
    logic        op_valid;
    logic [2:0]  operation;
    logic [31:0] amount;
    logic [15:0] new_pin;
    logic [2:0]  state;
    logic [31:0] balance;
    logic        done;
    logic [2:0]  status;
    logic        locked;

    int total = 0;
    int bad   = 0;

    atm_controller_p dut (
        .clk        (clk),
        .rst        (rst),
        .card_valid (card_valid),
        .acc_num    (acc_num),
        .pin_valid  (pin_valid),
        .pin        (pin),
        .op_valid   (op_valid),
        .operation  (operation),
        .amount     (amount),
        .new_pin    (new_pin),
        .state      (state),
        .balance    (balance),
        .done       (done),
        .status     (status),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_done(input string tag, input logic [2:0] st, input logic [2:0] sts,
                               input logic [31:0] bal);
        check({tag, ".done"},    32'(done),   32'd1);
        check({tag, ".status"},  32'(status), 32'(sts));
        check({tag, ".state"},   32'(state),  32'(st));
        check({tag, ".balance"}, balance,     bal);
        $display("txn %s: state=%0d status=%0d balance=%0h locked=%0d",
                 tag, state, status, balance, locked);
    endtask

    task automatic card(input logic [3:0] acc);
        card_valid = 1'b1;
        acc_num    = acc;
        step();
        card_valid = 1'b0;
    endtask

    task automatic enter_pin(input logic [15:0] p);
        pin_valid = 1'b1;
        pin       = p;
        step();
        pin_valid = 1'b0;
    endtask

    // Issues a MENU operation 1..4; after return the done cycle is visible
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] amt,
                         input logic [15:0] p, input logic [15:0] np);
        op_valid  = 1'b1;
        operation = op;
        amount    = amt;
        pin       = p;
        new_pin   = np;
        step();
        op_valid  = 1'b0;
        check({tag, ".opstate"}, 32'(state), 32'(op) + 32'd2);
        check({tag, ".nodone"},  32'(done),  32'd0);
        step();
    endtask

    task automatic do_exit(input string tag);
        op_valid  = 1'b1;
        operation = 3'd5;
        step();
        op_valid  = 1'b0;
        expect_done(tag, 3'd0, 3'd0, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        card_valid = 1'b0;
        acc_num    = '0;
        pin_valid  = 1'b0;
        pin        = '0;
        op_valid   = 1'b0;
        operation  = '0;
        amount     = '0;
        new_pin    = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst.state",   32'(state),  32'd0);
        check("rst.balance", balance,     32'd0);
        check("rst.done",    32'(done),   32'd0);
        check("rst.status",  32'(status), 32'd0);
        check("rst.locked",  32'(locked), 32'd0);

        // Account 3: login and transactions
        card(4'd3);
        check("a3.auth", 32'(state), 32'd1);
        enter_pin(16'h1234);
        expect_done("a3.login", 3'd2, 3'd0, 32'd500);
        do_op("a3.bal", 3'd1, 32'd0, 16'h1234, 16'h0);
        expect_done("a3.bal", 3'd2, 3'd0, 32'd500);
        do_op("a3.wd200", 3'd2, 32'd200, 16'h1234, 16'h0);
        expect_done("a3.wd200", 3'd2, 3'd0, 32'd300);
        do_op("a3.wd400", 3'd2, 32'd400, 16'h1234, 16'h0);
        expect_done("a3.wd400", 3'd2, 3'd3, 32'd300);
        do_op("a3.wd0", 3'd2, 32'd0, 16'h1234, 16'h0);
        expect_done("a3.wd0", 3'd2, 3'd0, 32'd300);
        do_op("a3.dep2000", 3'd3, 32'd2000, 16'h1234, 16'h0);
        expect_done("a3.dep2000", 3'd2, 3'd0, 32'd2300);
        do_op("a3.wd1900", 3'd2, 32'd1900, 16'h1234, 16'h0);
        expect_done("a3.wd1900", 3'd2, 3'd4, 32'd2300);
        do_exit("a3.exit");

        // Account 5: lockout after three wrong PINs
        card(4'd5);
        check("a5.auth", 32'(state), 32'd1);
        enter_pin(16'h1111);
        expect_done("a5.bad1", 3'd1, 3'd1, 32'd500);
        enter_pin(16'h2222);
        expect_done("a5.bad2", 3'd1, 3'd1, 32'd500);
        enter_pin(16'h3333);
        expect_done("a5.lock", 3'd0, 3'd2, 32'd0);
        check("a5.lockflag", 32'(locked), 32'd1);
        card(4'd5);
        expect_done("a5.relog", 3'd0, 3'd2, 32'd0);
        check("a5.relogflag", 32'(locked), 32'd1);

        // Out-of-range account number
        card(4'd12);
        expect_done("a12.badacc", 3'd0, 3'd5, 32'd0);

        // Account 1: overflow and PIN change
        card(4'd1);
        enter_pin(16'h1234);
        expect_done("a1.login", 3'd2, 3'd0, 32'd500);
        do_op("a1.dep", 3'd3, 32'hFFFF_FD0C, 16'h1234, 16'h0);
        expect_done("a1.dep", 3'd2, 3'd0, 32'hFFFF_FF00);
        do_op("a1.ovf", 3'd3, 32'h200, 16'h1234, 16'h0);
        expect_done("a1.ovf", 3'd2, 3'd7, 32'hFFFF_FF00);
        do_op("a1.cpbad", 3'd4, 32'd0, 16'h9999, 16'h4321);
        expect_done("a1.cpbad", 3'd2, 3'd1, 32'hFFFF_FF00);
        do_op("a1.cpok", 3'd4, 32'd0, 16'h1234, 16'h4321);
        expect_done("a1.cpok", 3'd2, 3'd0, 32'hFFFF_FF00);
        do_exit("a1.exit");
        card(4'd1);
        enter_pin(16'h1234);
        expect_done("a1.oldpin", 3'd1, 3'd1, 32'hFFFF_FF00);
        enter_pin(16'h4321);
        expect_done("a1.newpin", 3'd2, 3'd0, 32'hFFFF_FF00);

        // Idle in MENU: timeout on the 16th quiet edge
        repeat (15) step();
        check("tmo.pre.state", 32'(state), 32'd2);
        check("tmo.pre.done",  32'(done),  32'd0);
        step();
        expect_done("tmo", 3'd0, 3'd6, 32'd0);
        step();
        check("tmo.pulse", 32'(done),   32'd0);
        check("tmo.hold",  32'(status), 32'd6);

        // Reset during the WITHDRAW cycle abandons it and restores the database
        card(4'd3);
        enter_pin(16'h1234);
        expect_done("a3.login2", 3'd2, 3'd0, 32'd2300);
        op_valid  = 1'b1;
        operation = 3'd2;
        amount    = 32'd100;
        step();
        op_valid  = 1'b0;
        check("rwd.opstate", 32'(state), 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rwd.state",   32'(state),  32'd0);
        check("rwd.balance", balance,     32'd0);
        check("rwd.done",    32'(done),   32'd0);
        check("rwd.status",  32'(status), 32'd0);
        card(4'd3);
        enter_pin(16'h1234);
        expect_done("rwd.a3login", 3'd2, 3'd0, 32'd500);
        do_op("rwd.a3bal", 3'd1, 32'd0, 16'h1234, 16'h0);
        expect_done("rwd.a3bal", 3'd2, 3'd0, 32'd500);
        do_exit("rwd.a3exit");
        card(4'd5);
        check("rwd.a5auth", 32'(state), 32'd1);
        enter_pin(16'h1234);
        expect_done("rwd.a5login", 3'd2, 3'd0, 32'd500);
        check("rwd.a5lock", 32'(locked), 32'd0);
        do_exit("rwd.a5exit");
        card(4'd1);
        enter_pin(16'h1234);
        expect_done("rwd.a1login", 3'd2, 3'd0, 32'd500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/atm_controller_p.md
Name: atm_controller_p

Overview:
- Parametrised, fully synchronous next-generation ATM controller.
- Holds a per-account balance, PIN and lock database in registers and authenticates card sessions with bounded PIN retries and account lockout.
- Executes balance/withdraw/deposit/change-PIN transactions, enforcing a per-session withdrawal limit and an inactivity timeout.
- Sits between the front-end input sequencer and the display/status logic; reports every outcome as a one-cycle done pulse with a status code.

Parameters:
NUM_ACCOUNTS, 10, number of accounts in the database (indices 0..NUM_ACCOUNTS-1)
ACC_W, 4, account number width
PIN_W, 16, PIN width
AMT_W, 32, amount/balance width
INIT_BALANCE, 500, balance of every account after reset
DEFAULT_PIN, 16'h1234, PIN of every account after reset
MAX_TRIES, 3, consecutive wrong PINs before lockout
TIMEOUT_CYCLES, 16, idle cycles in AUTH/MENU before session abort
WITHDRAW_LIMIT, 2000, maximum total withdrawn per session

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
card_valid  in  1  card-insert strobe; qualifies acc_num
acc_num  in  ACC_W  account number
pin_valid  in  1  qualifies pin in AUTH
pin  in  PIN_W  entered PIN (also the confirmation PIN for CHANGE_PIN)
op_valid  in  1  qualifies operation/amount/new_pin in MENU
operation  in  3  1=BALANCE 2=WITHDRAW 3=DEPOSIT 4=CHANGE_PIN 5=EXIT
amount  in  AMT_W  transaction amount
new_pin  in  PIN_W  replacement PIN
state  out  3  0=IDLE 1=AUTH 2=MENU 3=BALANCE 4=WITHDRAW 5=DEPOSIT 6=CHANGE_PIN
balance  out  AMT_W  registered balance of the session account; 0 in IDLE
done  out  1  one-cycle outcome pulse
status  out  3  0=OK 1=BAD_PIN 2=LOCKED 3=INSUFFICIENT 4=LIMIT 5=BAD_ACCOUNT 6=TIMEOUT 7=OVERFLOW; valid with done, held until the next done
locked  out  1  lock flag of the session/last-addressed account

Behaviour:
- Reset: state=IDLE, balance=0, done=0, status=0, locked=0, tries=0, session_withdrawn=0, timer=0. All balances=INIT_BALANCE, all PINs=DEFAULT_PIN, all locks=0. Reset mid-transaction abandons it with no database write.
- All outputs are registered. done is high exactly one cycle after the deciding edge.
- IDLE, on card_valid:
  - acc_num>=NUM_ACCOUNTS: done, BAD_ACCOUNT, stay IDLE.
  - Account locked: done, LOCKED, locked=1, stay IDLE.
  - Otherwise: latch index, tries=0, go to AUTH.
- AUTH, on pin_valid:
  - Match: go to MENU, session_withdrawn=0, tries=0, done OK.
  - Mismatch: tries+1. If the new count equals MAX_TRIES: set the account lock, done LOCKED, go to IDLE. Else done BAD_PIN, stay in AUTH.
- MENU, on op_valid:
  - Latch amount and new_pin, go to the operation state.
  - EXIT: go to IDLE, done OK.
  - Codes 0, 6, 7: ignored; stay in MENU, no done.
- Each operation state lasts exactly one cycle, then returns to MENU with done. op_valid-to-done latency = 2 cycles.
- BALANCE: done OK.
- WITHDRAW:
  - amount>balance: INSUFFICIENT. This check takes priority over the limit check.
  - session_withdrawn+amount>WITHDRAW_LIMIT: LIMIT. Compute the sum at AMT_W+1 bits.
  - Otherwise subtract amount from the balance, add it to session_withdrawn, OK.
  - amount=0: OK, no change.
- DEPOSIT: if the AMT_W+1-bit sum carries out, OVERFLOW with the balance unchanged; else add, OK.
- CHANGE_PIN: if pin does not match the stored PIN, BAD_PIN with no write; this does not count toward tries. Otherwise write new_pin, OK.
- Timeout: timer counts every cycle in AUTH/MENU with no valid strobe. Any accepted strobe clears it; leaving the state clears it. When the timer reaches TIMEOUT_CYCLES: go to IDLE, done TIMEOUT.
- Strobes are ignored outside their own state (card_valid outside IDLE, pin_valid outside AUTH, op_valid outside MENU).
- A timeout and a strobe on the same cycle: the strobe wins.
- balance updates in the same cycle that done is asserted.

Test Plan:
- Reset, card_valid acc 3, pin 1234h -> AUTH then MENU, done OK; BALANCE -> 2 cycles later done OK, balance=500.
- Acc 3, WITHDRAW 200 -> balance 300, OK; WITHDRAW 400 -> INSUFFICIENT, 300 unchanged; DEPOSIT 2000, WITHDRAW 1900 -> LIMIT (200+1900>2000).
- Acc 5, three wrong PINs -> BAD_PIN, BAD_PIN, LOCKED; state IDLE; new card_valid acc 5 -> LOCKED, locked=1.
- card_valid acc 12 -> BAD_ACCOUNT, state stays IDLE.
- Acc 1 balance preset via deposits to FFFFFF00h, DEPOSIT 200h -> OVERFLOW, balance unchanged; CHANGE_PIN with pin=1234h, new_pin=4321h -> OK; EXIT, re-login with 4321h -> OK.
- In MENU, no strobes for 16 cycles -> done TIMEOUT, state IDLE; assert rst during the WITHDRAW cycle -> all balances 500, state IDLE.
